// File: rtl/mat_vec_sequencer.sv
// Feeds a 4-wide dot-product unit: latches one vertex, issues the four matrix
// rows on consecutive cycles and gathers the pipelined results for downstream.
module mat_vec_sequencer #(
  parameter int WIDTH       = 32,
  parameter int DOT_LATENCY = 2
) (
  input  logic             clk_in,
  input  logic             rst_in_n,
  input  logic             mat_we_in,
  input  logic [3:0]       mat_addr_in,
  input  logic [WIDTH-1:0] mat_data_in,
  input  logic             vtx_valid_in,
  output logic             vtx_ready_out,
  input  logic [WIDTH-1:0] vx_in,
  input  logic [WIDTH-1:0] vy_in,
  input  logic [WIDTH-1:0] vz_in,
  input  logic [WIDTH-1:0] vw_in,
  output logic [WIDTH-1:0] dp_x0_out,
  output logic [WIDTH-1:0] dp_x1_out,
  output logic [WIDTH-1:0] dp_x2_out,
  output logic [WIDTH-1:0] dp_x3_out,
  output logic [WIDTH-1:0] dp_y0_out,
  output logic [WIDTH-1:0] dp_y1_out,
  output logic [WIDTH-1:0] dp_y2_out,
  output logic [WIDTH-1:0] dp_y3_out,
  input  logic [WIDTH-1:0] dp_out_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [WIDTH-1:0] ox_out,
  output logic [WIDTH-1:0] oy_out,
  output logic [WIDTH-1:0] oz_out,
  output logic [WIDTH-1:0] ow_out
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid is never withdrawn and the payload stays stable until then.

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  localparam int               LAST = DOT_LATENCY - 1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << (WIDTH / 2);

  state_t                 state_q, state_d;
  logic [1:0]             row_q, row_d;
  logic [1:0]             row_nxt;
  logic [WIDTH-1:0]       mat_q [16];
  logic [WIDTH-1:0]       mat_d [16];
  logic [WIDTH-1:0]       vtx_q [4];
  logic [WIDTH-1:0]       vtx_d [4];
  logic [WIDTH-1:0]       dpx_q [4];
  logic [WIDTH-1:0]       dpx_d [4];
  logic [WIDTH-1:0]       res_q [4];
  logic [WIDTH-1:0]       res_d [4];
  logic [DOT_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [1:0]             tag_idx_q [DOT_LATENCY];
  logic [1:0]             tag_idx_d [DOT_LATENCY];
  logic                   res_valid_q, res_valid_d;
  logic                   vtx_ready_q, vtx_ready_d;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    row_nxt     = row_q + 2'd1;
    mat_d       = mat_q;
    vtx_d       = vtx_q;
    dpx_d       = dpx_q;
    res_d       = res_q;
    tag_vld_d   = tag_vld_q;
    tag_idx_d   = tag_idx_q;
    res_valid_d = res_valid_q;
    vtx_ready_d = vtx_ready_q;

    // Matrix is writable only between vertices so the one in flight sees a fixed matrix.
    if (state_q == IDLE && mat_we_in) mat_d[mat_addr_in] = mat_data_in;

    // Each issued row carries its index down a tag pipe matching the unit's latency.
    for (int i = LAST; i > 0; i--) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    tag_vld_d[0] = (state_q == ISSUE);
    tag_idx_d[0] = row_q;
    if (tag_vld_q[LAST]) res_d[tag_idx_q[LAST]] = dp_out_in;

    case (state_q)
      IDLE: begin
        if (vtx_valid_in) begin
          vtx_d       = '{vx_in, vy_in, vz_in, vw_in};
          row_d       = 2'd0;
          // Row 0 comes from mat_d so a write on the accepting edge is already visible.
          for (int c = 0; c < 4; c++) dpx_d[c] = mat_d[c];
          vtx_ready_d = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (row_q == 2'd3) begin
          state_d = DRAIN;
        end else begin
          row_d = row_nxt;
          for (int c = 0; c < 4; c++) dpx_d[c] = mat_q[{row_nxt, 2'(c)}];
        end
      end
      DRAIN: begin
        if (tag_vld_q[LAST] && tag_idx_q[LAST] == 2'd3) begin
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready_in) begin
          res_valid_d = 1'b0;
          vtx_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q     <= IDLE;
      row_q       <= 2'd0;
      for (int i = 0; i < 16; i++) mat_q[i] <= (i % 5 == 0) ? ONE : '0;
      for (int i = 0; i < 4; i++) begin
        vtx_q[i] <= '0;
        dpx_q[i] <= '0;
        res_q[i] <= '0;
      end
      tag_vld_q   <= '0;
      for (int i = 0; i < DOT_LATENCY; i++) tag_idx_q[i] <= 2'd0;
      res_valid_q <= 1'b0;
      vtx_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      mat_q       <= mat_d;
      vtx_q       <= vtx_d;
      dpx_q       <= dpx_d;
      res_q       <= res_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      res_valid_q <= res_valid_d;
      vtx_ready_q <= vtx_ready_d;
    end
  end

  assign vtx_ready_out = vtx_ready_q;
  assign res_valid_out = res_valid_q;
  assign dp_x0_out     = dpx_q[0];
  assign dp_x1_out     = dpx_q[1];
  assign dp_x2_out     = dpx_q[2];
  assign dp_x3_out     = dpx_q[3];
  assign dp_y0_out     = vtx_q[0];
  assign dp_y1_out     = vtx_q[1];
  assign dp_y2_out     = vtx_q[2];
  assign dp_y3_out     = vtx_q[3];
  assign ox_out        = res_q[0];
  assign oy_out        = res_q[1];
  assign oz_out        = res_q[2];
  assign ow_out        = res_q[3];

endmodule

// File: tb/tb_mat_vec_sequencer.sv
// Directed bench for mat_vec_sequencer with a behavioural 2-stage Q16.16 dot-product unit.
module tb_mat_vec_sequencer;

  localparam logic [31:0] ONE = 32'h0001_0000;

  logic        clk_in = 1'b0;
  logic        rst_in_n;
  logic        mat_we_in;
  logic [3:0]  mat_addr_in;
  logic [31:0] mat_data_in;
  logic        vtx_valid_in;
  logic        vtx_ready_out;
  logic [31:0] vx_in, vy_in, vz_in, vw_in;
  logic [31:0] dp_x0_out, dp_x1_out, dp_x2_out, dp_x3_out;
  logic [31:0] dp_y0_out, dp_y1_out, dp_y2_out, dp_y3_out;
  logic [31:0] dp_out_in;
  logic        res_valid_out;
  logic        res_ready_in;
  logic [31:0] ox_out, oy_out, oz_out, ow_out;

  int tests = 0;
  int fails = 0;
  int lat;

  mat_vec_sequencer #(.WIDTH(32), .DOT_LATENCY(2)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n),
    .mat_we_in(mat_we_in), .mat_addr_in(mat_addr_in), .mat_data_in(mat_data_in),
    .vtx_valid_in(vtx_valid_in), .vtx_ready_out(vtx_ready_out),
    .vx_in(vx_in), .vy_in(vy_in), .vz_in(vz_in), .vw_in(vw_in),
    .dp_x0_out(dp_x0_out), .dp_x1_out(dp_x1_out), .dp_x2_out(dp_x2_out), .dp_x3_out(dp_x3_out),
    .dp_y0_out(dp_y0_out), .dp_y1_out(dp_y1_out), .dp_y2_out(dp_y2_out), .dp_y3_out(dp_y3_out),
    .dp_out_in(dp_out_in),
    .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
    .ox_out(ox_out), .oy_out(oy_out), .oz_out(oz_out), .ow_out(ow_out)
  );

  always #5 clk_in = ~clk_in;

  // Dot-product unit model: Q16.16 products summed at full precision, result two edges later.
  function automatic logic [31:0] dot4(input logic [31:0] x0, x1, x2, x3, y0, y1, y2, y3);
    longint acc;
    acc = longint'($signed(x0)) * longint'($signed(y0)) + longint'($signed(x1)) * longint'($signed(y1))
        + longint'($signed(x2)) * longint'($signed(y2)) + longint'($signed(x3)) * longint'($signed(y3));
    return acc[47:16];
  endfunction

  logic [31:0] dp_s1 = '0;
  logic [31:0] dp_s2 = '0;
  always @(posedge clk_in) begin
    dp_s1 <= dot4(dp_x0_out, dp_x1_out, dp_x2_out, dp_x3_out,
                  dp_y0_out, dp_y1_out, dp_y2_out, dp_y3_out);
    dp_s2 <= dp_s1;
  end
  assign dp_out_in = dp_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk_in);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    mat_we_in = 1'b1; mat_addr_in = addr; mat_data_in = data;
    next();
    mat_we_in = 1'b0;
  endtask

  // Offers a vertex for one edge; returns in cycle 0 after the accept.
  task automatic send(input logic [31:0] a, b, c, d);
    vtx_valid_in = 1'b1; vx_in = a; vy_in = b; vz_in = c; vw_in = d;
    next();
    vtx_valid_in = 1'b0;
  endtask

  // Counts edges since the accept until res_valid_out, bounded.
  task automatic wait_res(input int start, output int n);
    n = start;
    while (res_valid_out !== 1'b1 && n < 40) begin
      next();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in_n = 1'b0; mat_we_in = 1'b0; mat_addr_in = '0; mat_data_in = '0;
    vtx_valid_in = 1'b0; vx_in = '0; vy_in = '0; vz_in = '0; vw_in = '0;
    res_ready_in = 1'b1;
    #12;
    chk("rst_ready", {31'd0, vtx_ready_out}, 32'd1);
    chk("rst_valid", {31'd0, res_valid_out}, 32'd0);
    chk("rst_ox", ox_out, 32'd0);
    chk("rst_dpx0", dp_x0_out, 32'd0);
    chk("rst_dpy0", dp_y0_out, 32'd0);
    rst_in_n = 1'b1;
    next();

    // Identity transform of (1,2,3,4).
    send(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
    chk("c0_ready", {31'd0, vtx_ready_out}, 32'd0);
    chk("c0_dpx0", dp_x0_out, ONE);
    chk("c0_dpx1", dp_x1_out, 32'd0);
    chk("c0_dpy1", dp_y1_out, 32'h0002_0000);
    next();
    chk("c1_dpx0", dp_x0_out, 32'd0);
    chk("c1_dpx1", dp_x1_out, ONE);
    wait_res(1, lat);
    chk("id_latency", 32'(lat), 32'd6);
    chk("id_ox", ox_out, 32'h0001_0000);
    chk("id_oy", oy_out, 32'h0002_0000);
    chk("id_oz", oz_out, 32'h0003_0000);
    chk("id_ow", ow_out, 32'h0004_0000);
    chk("id_ready_hold", {31'd0, vtx_ready_out}, 32'd0);
    next();
    chk("id_valid_clr", {31'd0, res_valid_out}, 32'd0);
    chk("id_ready_back", {31'd0, vtx_ready_out}, 32'd1);

    // Row 0 = (1,2,3,4), rows 1..3 = 0.
    wr(4'd0, 32'h0001_0000); wr(4'd1, 32'h0002_0000);
    wr(4'd2, 32'h0003_0000); wr(4'd3, 32'h0004_0000);
    for (int i = 4; i < 16; i++) wr(4'(i), 32'd0);
    send(32'h0001_8000, 32'h0004_C000, 32'h0008_D000, 32'h0010_0000);
    wait_res(0, lat);
    chk("r0_latency", 32'(lat), 32'd6);
    chk("r0_ox", ox_out, 32'h0065_7000);
    chk("r0_oy", oy_out, 32'd0);
    chk("r0_oz", oz_out, 32'd0);
    chk("r0_ow", ow_out, 32'd0);
    next();

    // Element 0 = -5.5 written on the same edge that accepts the vertex.
    mat_we_in = 1'b1; mat_addr_in = 4'd0; mat_data_in = 32'hFFFA_8000;
    send(32'h0001_8000, 32'h0004_C000, 32'h0008_D000, 32'hFFEF_8000);
    mat_we_in = 1'b0;
    wait_res(0, lat);
    chk("neg_ox", ox_out, 32'hFFD9_B000);
    chk("neg_oy", oy_out, 32'd0);
    next();

    // Backpressure: result held five cycles while another vertex waits.
    res_ready_in = 1'b0;
    send(ONE, ONE, ONE, ONE);
    wait_res(0, lat);
    chk("bp_latency", 32'(lat), 32'd6);
    vtx_valid_in = 1'b1; vx_in = 32'h0002_0000; vy_in = '0; vz_in = '0; vw_in = '0;
    for (int i = 0; i < 5; i++) begin
      next();
      chk("bp_valid", {31'd0, res_valid_out}, 32'd1);
      chk("bp_ox", ox_out, 32'h0003_8000);
      chk("bp_ready", {31'd0, vtx_ready_out}, 32'd0);
    end
    res_ready_in = 1'b1;
    next();
    chk("bp_rel_valid", {31'd0, res_valid_out}, 32'd0);
    chk("bp_rel_ready", {31'd0, vtx_ready_out}, 32'd1);
    chk("bp_rel_dpy0", dp_y0_out, ONE);
    next();
    vtx_valid_in = 1'b0;
    chk("bp_acc_ready", {31'd0, vtx_ready_out}, 32'd0);
    chk("bp_acc_dpy0", dp_y0_out, 32'h0002_0000);
    wait_res(0, lat);
    chk("bp2_latency", 32'(lat), 32'd6);
    chk("bp2_ox", ox_out, 32'hFFF5_0000);
    next();

    // Matrix write during ISSUE must be dropped.
    send(ONE, ONE, ONE, ONE);
    mat_we_in = 1'b1; mat_addr_in = 4'd12; mat_data_in = ONE;
    next();
    mat_we_in = 1'b0;
    wait_res(1, lat);
    chk("wp_ox", ox_out, 32'h0003_8000);
    chk("wp_ow", ow_out, 32'd0);
    next();
    send(ONE, ONE, ONE, ONE);
    wait_res(0, lat);
    chk("wp_next_ow", ow_out, 32'd0);
    next();

    // Asynchronous reset during DRAIN, then identity again.
    send(ONE, ONE, ONE, ONE);
    for (int i = 0; i < 4; i++) next();
    #2 rst_in_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, res_valid_out}, 32'd0);
    chk("ar_ready", {31'd0, vtx_ready_out}, 32'd1);
    chk("ar_ox", ox_out, 32'd0);
    chk("ar_dpx0", dp_x0_out, 32'd0);
    chk("ar_dpy0", dp_y0_out, 32'd0);
    #1 rst_in_n = 1'b1;
    next();
    send(32'h0005_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000);
    wait_res(0, lat);
    chk("ar_latency", 32'(lat), 32'd6);
    chk("ar_id_ox", ox_out, 32'h0005_0000);
    chk("ar_id_oy", oy_out, 32'hFFFF_FFFF);
    chk("ar_id_oz", oz_out, 32'h7FFF_FFFF);
    chk("ar_id_ow", ow_out, 32'h8000_0000);
    next();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mat_vec_sequencer.md
Name: mat_vec_sequencer

Overview:
- Upstream feeder for the 4-wide Q16.16 dotProduct unit in the vertex-transform path.
- Holds a 4x4 Q16.16 transform matrix.
- Accepts one 4-component vertex through a valid/ready handshake, issues the four matrix rows against that vertex to the dot-product unit on consecutive cycles, and collects the four pipelined results.
- Presents the transformed vertex downstream through a valid/ready handshake.

Parameters:
WIDTH, 32, bit width of every matrix element, vertex component and result (Q16.16 when 32).
DOT_LATENCY, 2, number of rising edges from a cycle in which dp_* inputs are presented to the cycle in which dp_out_in holds the matching result.

Ports:
clk_in  input  1  system clock, rising edge.
rst_in_n  input  1  reset; one clock; reset is asynchronous and active-low.
mat_we_in  input  1  matrix element write strobe.
mat_addr_in  input  4  element index, row*4+col.
mat_data_in  input  WIDTH  element value, signed.
vtx_valid_in  input  1  input vertex valid.
vtx_ready_out  output  1  sequencer can accept a vertex.
vx_in, vy_in, vz_in, vw_in  input  WIDTH each  input vertex components, signed.
dp_x0_out..dp_x3_out  output  WIDTH each  current matrix row to dotProduct x0..x3.
dp_y0_out..dp_y3_out  output  WIDTH each  latched vertex to dotProduct y0..y3.
dp_out_in  input  WIDTH  dotProduct result.
res_valid_out  output  1  transformed vertex valid.
res_ready_in  input  1  downstream accepts result.
ox_out, oy_out, oz_out, ow_out  output  WIDTH each  transformed components (rows 0..3).

Behaviour:
- Reset (asynchronous, while rst_in_n=0):
  - Matrix set to identity: diagonal 0x00010000, all else 0.
  - State IDLE; vtx_ready_out=1; res_valid_out=0.
  - All o*_out, dp_*_out and the vertex latch are 0.
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - vtx_ready_out=1.
  - mat_we_in writes mat_data_in to element mat_addr_in at the clock edge.
  - Accept on vtx_valid_in && vtx_ready_out: latch vertex, row counter=0, go to ISSUE.
  - A write and an accept at the same edge: the write lands first, so the accepted vertex sees the new element.
- Cycle numbering: cycle 0 is the cycle following the accepting edge.
- ISSUE:
  - Row r is driven on dp_x*_out in cycle r (r=0..3).
  - dp_y*_out carry the latched vertex from cycle 0 until the result is consumed.
  - After cycle 3, go to DRAIN.
- Result capture:
  - A DOT_LATENCY-deep shift register tags each issued row with its index.
  - The result for row r is captured from dp_out_in at the end of cycle r+DOT_LATENCY into ox/oy/oz/ow respectively.
- DRAIN: wait until row 3's result is captured (end of cycle 3+DOT_LATENCY), then go to HOLD.
- HOLD:
  - res_valid_out=1 from edge E(4+DOT_LATENCY) after the accept (edge 6 with the default).
  - o*_out are stable while res_valid_out && !res_ready_in.
  - On res_valid_out && res_ready_in: clear res_valid_out and go to IDLE.
  - vtx_ready_out rises on the same edge.
- Timing and throughput:
  - vtx_ready_out=0 in every state except IDLE; there is no overlap between vertices.
  - Minimum spacing between accepts is 6+DOT_LATENCY edges.
- Matrix write protection: mat_we_in outside IDLE is ignored (dropped, no queue); the matrix stays constant for the vertex in flight.
- Arithmetic: none internal; the sequencer only routes data, with no saturation or rounding. o*_out equal dp_out_in bit-exact.
- dp_x*_out when not in ISSUE: hold the last driven row; the value is don't-care but must be stable.
- Reset mid-operation: immediate abort to the reset state; in-flight results are discarded and the matrix returns to identity.

Test Plan:
- Identity after reset, vertex (1,2,3,4) = 0x00010000,0x00020000,0x00030000,0x00040000, res_ready_in=1 -> res_valid_out rises exactly 6 edges after accept; outputs equal the input vertex; vtx_ready_out high the following cycle.
- Write row 0 = (1,2,3,4) and rows 1-3 = 0, vertex (1.5,4.75,8.8125,16.0) -> ox_out=0x00657000 (101.4375), oy/oz/ow=0.
- Row 0 = (-5.5,2,3,4) (0xFFFA8000,...), vertex (1.5,4.75,8.8125,-16.5) -> ox_out=-38.3125 (0xFFD9B000).
- Backpressure: res_ready_in=0 for 5 cycles after res_valid_out -> outputs and res_valid_out held; vtx_ready_out=0 throughout; a vertex offered meanwhile is not accepted until after the release edge.
- mat_we_in pulsed during ISSUE -> matrix unchanged; the next vertex uses the old element.
- Deassert rst_in_n during DRAIN -> asynchronously res_valid_out=0, vtx_ready_out=1, outputs 0; the next vertex is transformed by identity.
